// File: rtl/bcd_sevenseg_scan_pkg.sv
// -----------------------------------------------------------------------------
// bcd_sevenseg_scan_pkg
// Shared definitions for the multiplexed 7-segment display blocks:
//   - seg_t            : 7-bit segment vector, bit order {g,f,e,d,c,b,a}
//   - SEG_BIT_A/G      : bit positions of segment a (LSB) and g (MSB)
//   - SEG_0..SEG_9     : active-high glyphs for decimal digits
//   - SEG_DASH         : active-high glyph for non-decimal codes (g only)
//   - SEG_BLANK        : all segments off (active-high)
//   - clog2()          : ceiling log2 with a minimum result of 1, for widths
// -----------------------------------------------------------------------------
package bcd_sevenseg_scan_pkg;

    localparam int SEG_BIT_A = 0;
    localparam int SEG_BIT_G = 6;

    typedef logic [SEG_BIT_G:SEG_BIT_A] seg_t;

    localparam seg_t SEG_0     = 7'b0111111;
    localparam seg_t SEG_1     = 7'b0000110;
    localparam seg_t SEG_2     = 7'b1011011;
    localparam seg_t SEG_3     = 7'b1001111;
    localparam seg_t SEG_4     = 7'b1100110;
    localparam seg_t SEG_5     = 7'b1101101;
    localparam seg_t SEG_6     = 7'b1111101;
    localparam seg_t SEG_7     = 7'b0000111;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1101111;
    localparam seg_t SEG_DASH  = 7'b1000000;
    localparam seg_t SEG_BLANK = 7'b0000000;

    // Width needed to hold values 0..value-1; never returns less than 1 so
    // that a degenerate parameter still yields a legal vector.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_sevenseg_scan_decode.sv
// -----------------------------------------------------------------------------
// bcd_to_sevenseg
// Combinational 4-bit BCD to 7-segment decoder, active-high outputs.
// Codes 10..15 are not decimal and are shown as a dash so that a corrupted
// counter value is visible on the display rather than silently mis-shown.
//   bcd_i : 4-bit digit code
//   seg_o : segments {g,f,e,d,c,b,a}, 1 = lit
// -----------------------------------------------------------------------------
module bcd_to_sevenseg
    import bcd_sevenseg_scan_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// -----------------------------------------------------------------------------
// bcd_sevenseg_scan
// Time-multiplexed 7-segment driver for a chain of BCD digits.
// A prescaler divides clk into digit slots; each slot drives one digit enable
// after a short all-off guard interval (anti-ghosting). Inputs are captured
// once per frame so a counter rolling over mid-scan never tears the display.
//
// Ports:
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   bcd_in      : packed BCD digits, [3:0] = least-significant digit
//   dp_in       : decimal point request per digit
//   blank_lz    : 1 = blank leading zeros
//   seg         : segments {g,f,e,d,c,b,a} at SEG_ACTIVE_LOW polarity
//   dp          : decimal point of the active digit, same polarity as seg
//   an          : digit enables at DIGIT_ACTIVE_LOW polarity, bit i = digit i
//   digit_idx   : current slot index
//   frame_start : one-cycle pulse on the first cycle of slot 0
// -----------------------------------------------------------------------------
module bcd_sevenseg_scan
    import bcd_sevenseg_scan_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int GUARD_CYCLES     = 2,
    parameter int SEG_ACTIVE_LOW   = 1,
    parameter int DIGIT_ACTIVE_LOW = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4*NUM_DIGITS-1:0]       bcd_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          blank_lz,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [clog2(NUM_DIGITS)-1:0]  digit_idx,
    output logic                          frame_start
);

    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam int PRE_W = clog2(REFRESH_DIV);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_GUARD = PRE_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Pin levels meaning "off"; XOR-ing an active-high value with these
    // yields the configured output polarity.
    localparam seg_t                  SEG_OFF_LVL = {7{SEG_ACTIVE_LOW != 0}};
    localparam logic                  DP_OFF_LVL  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF_LVL  = {NUM_DIGITS{DIGIT_ACTIVE_LOW != 0}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PRE_W-1:0]          prescaler_q, prescaler_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   snap_bcd_q, snap_bcd_d;
    logic [NUM_DIGITS-1:0]     snap_dp_q, snap_dp_d;
    logic                      snap_blz_q, snap_blz_d;
    logic                      frame_start_q, frame_start_d;
    seg_t                      seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;

    logic slot_tick;
    logic frame_wrap;
    logic in_guard;

    assign slot_tick  = (prescaler_q == PRE_LAST);
    assign frame_wrap = slot_tick && (idx_q == IDX_LAST);
    assign in_guard   = (prescaler_q < PRE_GUARD);

    // ------------------------------------------------------------------
    // Per-digit views of the snapshot
    // ------------------------------------------------------------------
    logic [3:0]            digit_code [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [NUM_DIGITS-1:0] sel_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_code[gi] = snap_bcd_q[4*gi +: 4];
            assign sel_onehot[gi] = (idx_q == IDX_W'(gi));

            // A digit is a leading zero when it and everything above it is
            // zero. Non-decimal codes are non-zero, so they end the run.
            if (gi == 0) begin : g_lsd
                assign blank_mask[gi] = 1'b0;
            end else begin : g_upper
                assign blank_mask[gi] = snap_blz_q &&
                    (snap_bcd_q[4*NUM_DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Current-slot selection and decode
    // ------------------------------------------------------------------
    logic [3:0] cur_code;
    logic       cur_blank;
    logic       cur_dp;
    seg_t       cur_glyph;

    always_comb begin
        cur_code  = 4'd0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_onehot[i]) begin
                cur_code  = digit_code[i];
                cur_blank = blank_mask[i];
                cur_dp    = snap_dp_q[i];
            end
        end
    end

    bcd_to_sevenseg u_decode (
        .bcd_i (cur_code),
        .seg_o (cur_glyph)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        prescaler_d   = slot_tick ? '0 : prescaler_q + 1'b1;

        idx_d         = idx_q;
        if (slot_tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        snap_bcd_d    = snap_bcd_q;
        snap_dp_d     = snap_dp_q;
        snap_blz_d    = snap_blz_q;
        if (frame_wrap) begin
            snap_bcd_d = bcd_in;
            snap_dp_d  = dp_in;
            snap_blz_d = blank_lz;
        end

        frame_start_d = frame_wrap;

        // Outputs are registered from the current slot state. The capture
        // lands on the same edge that enters slot 0, so the first output
        // update of slot 0 already decodes the freshly captured frame.
        seg_d = (cur_blank ? SEG_BLANK : cur_glyph) ^ SEG_OFF_LVL;
        dp_d  = cur_dp ^ DP_OFF_LVL;
        an_d  = (in_guard ? '0 : sel_onehot) ^ AN_OFF_LVL;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_q   <= '0;
            idx_q         <= '0;
            snap_bcd_q    <= '0;
            snap_dp_q     <= '0;
            snap_blz_q    <= 1'b0;
            frame_start_q <= 1'b0;
            seg_q         <= SEG_OFF_LVL;
            dp_q          <= DP_OFF_LVL;
            an_q          <= AN_OFF_LVL;
        end else begin
            prescaler_q   <= prescaler_d;
            idx_q         <= idx_d;
            snap_bcd_q    <= snap_bcd_d;
            snap_dp_q     <= snap_dp_d;
            snap_blz_q    <= snap_blz_d;
            frame_start_q <= frame_start_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign digit_idx   = idx_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_sevenseg_scan
// Two instances share stimulus: dut_a with active-low outputs, dut_b with
// active-high outputs. A time-based model (edge count since reset) predicts
// every output; literal checks at known edges pin the model to hand values.
// -----------------------------------------------------------------------------
module tb_bcd_sevenseg_scan;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int G  = 1;
    localparam int RN = R * N;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  an_a, an_b;
    logic [1:0]  idx_a, idx_b;
    logic        fs_a, fs_b;

    always #5 clk = ~clk;

    bcd_sevenseg_scan #(
        .NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYCLES(G),
        .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1)
    ) dut_a (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in),
        .blank_lz(blank_lz), .seg(seg_a), .dp(dp_a), .an(an_a),
        .digit_idx(idx_a), .frame_start(fs_a)
    );

    bcd_sevenseg_scan #(
        .NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYCLES(G),
        .SEG_ACTIVE_LOW(0), .DIGIT_ACTIVE_LOW(0)
    ) dut_b (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in),
        .blank_lz(blank_lz), .seg(seg_b), .dp(dp_b), .an(an_b),
        .digit_idx(idx_b), .frame_start(fs_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (edge %0d, t=%0t)", nm, got, exp, n_cnt, $time);
        end
    endtask

    // Glyph table as written in the display datasheet, active-high {g..a}.
    function automatic logic [6:0] glyph(input int code);
        case (code)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Reference model: n_cnt = clock edges since reset released. State
    // k has slot position k%R and digit (k/R)%N; outputs seen after edge
    // n are those of state n-1. Frames are captured at every edge that is
    // a multiple of R*N.
    // ------------------------------------------------------------------
    int          n_cnt = 0;
    logic [15:0] m_bcd;
    logic [3:0]  m_dp;
    logic        m_blz;
    int          m_p, m_d, m_digit;
    logic        m_blank;
    logic [6:0]  e_seg_on = 7'd0;
    logic        e_dp_on = 1'b0;
    logic [3:0]  e_an_on = 4'd0;
    int          e_idx = 0;
    logic        e_fs = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n_cnt = 0;
            m_bcd = 16'h0; m_dp = 4'h0; m_blz = 1'b0;
            e_seg_on = 7'd0; e_dp_on = 1'b0; e_an_on = 4'd0;
            e_idx = 0; e_fs = 1'b0;
        end else begin
            m_p     = n_cnt % R;
            m_d     = (n_cnt / R) % N;
            m_digit = int'((m_bcd >> (4 * m_d)) & 16'hF);
            m_blank = m_blz && (m_d != 0) && ((m_bcd >> (4 * m_d)) == 16'd0);
            e_seg_on = m_blank ? 7'd0 : glyph(m_digit);
            e_dp_on  = m_dp[m_d];
            e_an_on  = (m_p < G) ? 4'd0 : 4'(1 << m_d);
            n_cnt++;
            e_idx = (n_cnt / R) % N;
            e_fs  = ((n_cnt % RN) == 0);
            if (e_fs) begin
                m_bcd = bcd_in; m_dp = dp_in; m_blz = blank_lz;
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    logic [6:0] x_seg_lo;
    logic       x_dp_lo;
    logic [3:0] x_an_lo;
    logic [1:0] x_idx;

    always @(negedge clk) begin
        if (cmp_en) begin
            x_seg_lo = ~e_seg_on;
            x_dp_lo  = ~e_dp_on;
            x_an_lo  = ~e_an_on;
            x_idx    = 2'(e_idx);
            chk("seg_a", seg_a, x_seg_lo);
            chk("dp_a",  dp_a,  x_dp_lo);
            chk("an_a",  an_a,  x_an_lo);
            chk("idx_a", idx_a, x_idx);
            chk("fs_a",  fs_a,  e_fs);
            chk("seg_b", seg_b, e_seg_on);
            chk("dp_b",  dp_b,  e_dp_on);
            chk("an_b",  an_b,  e_an_on);
            chk("idx_b", idx_b, x_idx);
            chk("fs_b",  fs_b,  e_fs);
        end
    end

    // Wait (bounded) until the given edge count has been reached; we end
    // on the falling edge right after that rising edge.
    task automatic goto(input int t);
        int budget;
        budget = 0;
        while (n_cnt < t && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (n_cnt != t) begin
            n_cmp++;
            n_bad++;
            $display("FAIL goto: reached edge %0d, required %0d", n_cnt, t);
        end
    endtask

    task automatic set_in(input logic [15:0] b, input logic [3:0] d, input logic z);
        bcd_in = b; dp_in = d; blank_lz = z;
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        v = 16'h0;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                v[4*i +: 4] = 4'($urandom_range(0, 15));
            end
        end
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", n_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(16'h1234, 4'h0, 1'b0);
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);

        // Reset held with the clock running.
        chk("rst an_a",  an_a,  4'b1111);
        chk("rst seg_a", seg_a, 7'b1111111);
        chk("rst dp_a",  dp_a,  1'b1);
        chk("rst an_b",  an_b,  4'b0000);
        chk("rst seg_b", seg_b, 7'b0000000);
        chk("rst fs_a",  fs_a,  1'b0);
        rst = 1'b0;

        // Scan order with 1234 (captured at edge 16, shown in frame 2).
        goto(16); chk("fs first", fs_a, 1'b1);
        goto(17); chk("guard an", an_a, 4'b1111); chk("fs drop", fs_a, 1'b0);
        goto(19); chk("d0 an", an_a, 4'b1110); chk("d0 seg 4", seg_a, 7'b0011001);
        goto(23); chk("d1 an", an_a, 4'b1101); chk("d1 seg 3", seg_a, 7'b0110000);
        goto(27); chk("d2 an", an_a, 4'b1011); chk("d2 seg 2", seg_a, 7'b0100100);
        goto(31); chk("d3 an", an_a, 4'b0111); chk("d3 seg 1", seg_a, 7'b1111001);
        set_in(16'h0050, 4'h0, 1'b1);
        goto(32); chk("fs period", fs_a, 1'b1);

        // Leading-zero blanking.
        goto(35); chk("lz d0 0", seg_a, 7'b1000000);
        goto(39); chk("lz d1 5", seg_a, 7'b0010010);
        goto(43); chk("lz d2 blank", seg_a, 7'b1111111);
        goto(47); chk("lz d3 blank", seg_a, 7'b1111111);
        set_in(16'h0000, 4'h0, 1'b1);
        goto(51); chk("zero d0", seg_a, 7'b1000000);
        goto(55); chk("zero d1 blank", seg_a, 7'b1111111); chk("zero d1 an", an_a, 4'b1101);
        goto(63);
        set_in(16'h00A7, 4'b0010, 1'b1);

        // Invalid code and decimal point.
        goto(67); chk("inv d0 7", seg_a, 7'b1111000); chk("inv d0 dp", dp_a, 1'b1);
        goto(71); chk("inv d1 dash", seg_a, 7'b0111111); chk("inv d1 dp", dp_a, 1'b0);
        goto(75); chk("inv d2 blank", seg_a, 7'b1111111);
        goto(79); chk("inv d3 blank", seg_a, 7'b1111111);
        set_in(16'h1111, 4'h0, 1'b0);

        // Snapshot integrity: change inputs during slot 2.
        goto(90); set_in(16'h2222, 4'h0, 1'b0);
        goto(91); chk("snap d2 1", seg_a, 7'b1111001);
        goto(95); chk("snap d3 1", seg_a, 7'b1111001);
        goto(99); chk("next d0 2", seg_a, 7'b0100100);
        goto(111); chk("next d3 2", seg_a, 7'b0100100);
        set_in(16'h0008, 4'h0, 1'b0);

        // Active-high instance.
        goto(113); chk("pol guard an_b", an_b, 4'b0000);
        goto(115); chk("pol an_b", an_b, 4'b0001); chk("pol seg_b 8", seg_b, 7'b1111111);

        // Asynchronous reset mid-slot.
        goto(117);
        #2 rst = 1'b1;
        #1;
        chk("arst an_a",  an_a,  4'b1111);
        chk("arst seg_a", seg_a, 7'b1111111);
        chk("arst dp_a",  dp_a,  1'b1);
        chk("arst idx_a", idx_a, 2'd0);
        chk("arst an_b",  an_b,  4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic with occasional mid-scan resets.
        for (int it = 0; it < 500; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) begin
                set_in(rand_bcd(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
